// File: rtl/taylor_trig_engine.sv
// Taylor-series cos/sin engine in signed fixed point. Terms are built by recurrence
// t_k = t_{k-1} * x^2 * c_k, with one ROM coefficient fetched per term.
module taylor_trig_engine #(
  parameter int unsigned W      = 16,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned NTERMS = 8,
  localparam int unsigned AW    = $clog2(NTERMS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  thresh,
  output logic [AW-1:0] coef_addr,
  input  logic [W-1:0]  coef_data,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [AW-1:0] terms_used,
  output logic          ovf
);

  localparam int unsigned KW = AW - 1;
  localparam int unsigned TW = AW;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSqr  = 3'd1;
  localparam logic [2:0] StMulX2 = 3'd2;
  localparam logic [2:0] StMulC = 3'd3;
  localparam logic [2:0] StAcc  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam logic [W-1:0] One  = W'(1) << FRAC;
  localparam logic [W-1:0] MinV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxV = {1'b0, {(W-1){1'b1}}};

  logic [2:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  x2_q, x2_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] coef_addr_q, coef_addr_d;
  logic [TW-1:0] terms_q, terms_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  mul_a, mul_b;
  logic [W:0]    mul_res;
  logic [W:0]    acc_res;
  logic [W-1:0]  t_abs;
  logic          stop;

  // Returns {saturated, value}: floor(a*b / 2^FRAC) clamped to W bits.
  function automatic logic [W:0] sat_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    p = p >>> FRAC;
    if (p[2*W-1:W-1] == '0 || p[2*W-1:W-1] == '1) begin
      return {1'b0, p[W-1:0]};
    end
    return {1'b1, p[2*W-1], {(W-1){~p[2*W-1]}}};
  endfunction

  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0] bx;
    logic [W:0] s;
    bx = {b[W-1], b};
    s  = {a[W-1], a} + (sub ? -bx : bx);
    if (s[W] == s[W-1]) begin
      return {1'b0, s[W-1:0]};
    end
    return {1'b1, s[W], {(W-1){~s[W]}}};
  endfunction

  // One shared multiplier; each state uses it for a single product.
  always_comb begin
    mul_a = t_q;
    mul_b = x2_q;
    unique case (state_q)
      StSqr:   begin mul_a = x_q; mul_b = x_q;      end
      StMulC:  begin mul_a = t_q; mul_b = coef_data; end
      default: begin mul_a = t_q; mul_b = x2_q;     end
    endcase
  end

  assign mul_res = sat_mul(mul_a, mul_b);
  assign acc_res = sat_add(r_q, t_q, k_q[0]);
  assign t_abs   = (t_q == MinV) ? MaxV : (t_q[W-1] ? -t_q : t_q);
  assign stop    = (k_q == KW'(NTERMS - 1)) || ((thresh != '0) && (t_abs < thresh));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    x2_d        = x2_q;
    t_d         = t_q;
    r_d         = r_q;
    k_d         = k_q;
    coef_addr_d = coef_addr_q;
    terms_d     = terms_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x_in;
          mode_d  = mode;
          ovf_d   = 1'b0;
          state_d = StSqr;
        end
      end
      StSqr: begin
        x2_d    = mul_res[W-1:0];
        ovf_d   = ovf_q | mul_res[W];
        k_d     = KW'(1);
        r_d     = mode_q ? x_q : One;
        t_d     = mode_q ? x_q : One;
        terms_d = TW'(1);
        state_d = StMulX2;
      end
      StMulX2: begin
        t_d         = mul_res[W-1:0];
        ovf_d       = ovf_q | mul_res[W];
        coef_addr_d = {mode_q, k_q};
        state_d     = StMulC;
      end
      StMulC: begin
        t_d     = mul_res[W-1:0];
        ovf_d   = ovf_q | mul_res[W];
        state_d = StAcc;
      end
      StAcc: begin
        r_d     = acc_res[W-1:0];
        ovf_d   = ovf_q | acc_res[W];
        terms_d = TW'(k_q) + TW'(1);
        if (stop) begin
          result_d = acc_res[W-1:0];
          state_d  = StDone;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = StMulX2;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      x_q         <= '0;
      x2_q        <= '0;
      t_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      coef_addr_q <= '0;
      terms_q     <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      x2_q        <= x2_d;
      t_q         <= t_d;
      r_q         <= r_d;
      k_q         <= k_d;
      coef_addr_q <= coef_addr_d;
      terms_q     <= terms_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign coef_addr  = coef_addr_q;
  assign result     = result_q;
  assign terms_used = terms_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_taylor_trig_engine.sv
// Directed and randomized checks of taylor_trig_engine against a plain-arithmetic
// Taylor-series model using the same coefficient formulas as the system ROM.
module tb_taylor_trig_engine;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic signed [15:0] x_in = '0;
  logic [15:0]        thresh = '0;
  logic [3:0]         coef_addr;
  logic [15:0]        coef_data;
  logic               busy, done, ovf;
  logic [15:0]        result;
  logic [3:0]         terms_used;

  int n_checks = 0;
  int n_err    = 0;
  int p1 = -1;
  int p2 = -1;
  longint addr_q[$];
  longint rom [16];

  always #5 clk = ~clk;

  taylor_trig_engine #(.W(16), .FRAC(14), .NTERMS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .x_in       (x_in),
    .thresh     (thresh),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .terms_used (terms_used),
    .ovf        (ovf)
  );

  assign coef_data = 16'(rom[coef_addr]);

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v, inout bit ov);
    if (v > 32767) begin ov = 1'b1; return 32767; end
    if (v < -32768) begin ov = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b, inout bit ov);
    return sat16((a * b) >>> 14, ov);
  endfunction

  // Series sum_k (-1)^k x^(2k[+1])/(2k[+1])! evaluated term-by-term in Q2.14.
  task automatic model(input longint x, input bit md, input longint th,
                       output longint res, output int terms, output bit ov);
    longint x2, t, r, at;
    ov    = 1'b0;
    x2    = fmul(x, x, ov);
    t     = md ? x : 16384;
    r     = t;
    terms = 1;
    for (int k = 1; k < 8; k++) begin
      t     = fmul(t, x2, ov);
      t     = fmul(t, rom[(md ? 8 : 0) + k], ov);
      r     = (k % 2 == 1) ? sat16(r - t, ov) : sat16(r + t, ov);
      terms = k + 1;
      at    = (t == -32768) ? 32767 : ((t < 0) ? -t : t);
      if (th != 0 && at < th) break;
    end
    res = r;
  endtask

  task automatic run_op(input longint x, input bit md, input longint th, input string tag,
                        input bit chk_addr);
    longint exp_res;
    int     exp_terms;
    bit     exp_ov;
    int     cyc;
    model(x, md, th, exp_res, exp_terms, exp_ov);
    start  = 1'b1;
    x_in   = 16'(x);
    mode   = md;
    thresh = 16'(th);
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 16'sh5a5a;
    mode  = ~md;
    chk({tag, ":busy_after_accept"}, busy, 1);
    addr_q.delete();
    cyc = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == p1 || cyc == p2);
      if (!done && cyc % 3 == 2) addr_q.push_back(coef_addr);
      if (done) break;
      if (cyc > 60) begin
        chk({tag, ":timeout"}, cyc, 1 + 3 * (exp_terms - 1));
        break;
      end
    end
    start = 1'b0;
    chk({tag, ":latency"}, cyc, 1 + 3 * (exp_terms - 1));
    chk({tag, ":busy_in_done"}, busy, 1);
    chk({tag, ":result"}, longint'($signed(result)), exp_res);
    chk({tag, ":terms_used"}, terms_used, exp_terms);
    chk({tag, ":ovf"}, ovf, exp_ov);
    if (chk_addr) begin
      chk({tag, ":addr_count"}, addr_q.size(), exp_terms - 1);
      foreach (addr_q[i]) chk({tag, ":coef_addr"}, addr_q[i], (md ? 8 : 0) + i + 1);
    end
    @(posedge clk);
    #1;
    chk({tag, ":done_pulse_1cyc"}, done, 0);
    chk({tag, ":idle_after_done"}, busy, 0);
    chk({tag, ":result_held"}, longint'($signed(result)), exp_res);
    chk({tag, ":ovf_held"}, ovf, exp_ov);
  endtask

  initial begin
    longint xr, th;
    bit     md;
    for (int k = 0; k < 8; k++) begin
      rom[k]     = (k == 0) ? 0 : (2 * 16384 + (2*k-1)*(2*k)) / (2 * (2*k-1)*(2*k));
      rom[8 + k] = (k == 0) ? 0 : (2 * 16384 + (2*k)*(2*k+1)) / (2 * (2*k)*(2*k+1));
    end

    #3;
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:result", result, 0);
    chk("reset:ovf", ovf, 0);
    chk("reset:coef_addr", coef_addr, 0);
    chk("reset:terms_used", terms_used, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 1'b0, 0, "cos0", 1'b1);
    chk("cos0:spec_result", result, 16384);
    run_op(0, 1'b0, 1, "cos0_thr", 1'b1);
    chk("cos0_thr:terms", terms_used, 2);
    run_op(16384, 1'b0, 0, "cos1", 1'b1);
    chk("cos1:near_8852", (longint'($signed(result)) >= 8836 &&
                           longint'($signed(result)) <= 8868), 1);
    run_op(-8192, 1'b1, 0, "sin_m05", 1'b1);
    run_op(32767, 1'b0, 0, "sat", 1'b0);
    chk("sat:ovf_set", ovf, 1);
    run_op(8192, 1'b0, 0, "after_sat", 1'b0);

    p1 = 3;
    p2 = 10;
    run_op(12000, 1'b1, 0, "ignored_start", 1'b0);
    p1 = -1;
    p2 = -1;

    // Abort a saturating run at cycle 12 with an asynchronous reset.
    start  = 1'b1;
    x_in   = 16'sd32767;
    mode   = 1'b0;
    thresh = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst:busy_before", busy, 1);
    chk("midrst:ovf_before", ovf, 1);
    rst = 1'b0;
    #1;
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done, 0);
    chk("midrst:result", result, 0);
    chk("midrst:ovf", ovf, 0);
    @(posedge clk);
    #1;
    chk("midrst:no_done", done, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(16384, 1'b0, 0, "post_rst_cos1", 1'b1);

    for (int i = 0; i < 8; i++) begin
      xr = longint'($urandom_range(0, 49152)) - 24576;
      md = 1'($urandom_range(0, 1));
      th = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(1, 300)) : 0;
      run_op(xr, md, th, $sformatf("rand%0d", i), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
